// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller:
// forwarding select codes, shadow stage entry and the PC register id.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic       rf_e;
        logic       load;
        logic [3:0] dest;
    } stage_ent_t;

    localparam logic [3:0] REG_PC = 4'd15;

    function automatic logic ent_hit(
        stage_ent_t e,
        logic       used,
        logic [3:0] src
    );
        return used & e.valid & e.rf_e &
               (e.dest == src) & (src != REG_PC);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID-side hazard bundle: decoded source/dest fields in,
// forwarding selects, stall/flush controls and counters out.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_ra;
    logic [3:0]       id_rb;
    logic [3:0]       id_rd;
    logic             id_use_ra;
    logic             id_use_rb;
    logic             id_use_rd;
    logic             id_rf_e;
    logic             id_load;
    logic             branch_taken;
    logic [1:0]       sel_pa;
    logic [1:0]       sel_pb;
    logic [1:0]       sel_pd;
    logic             pc_le;
    logic             ifid_le;
    logic             nop_ex;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_ra, id_rb, id_rd,
        output id_use_ra, id_use_rb, id_use_rd,
        output id_rf_e, id_load, branch_taken,
        input  sel_pa, sel_pb, sel_pd,
        input  pc_le, ifid_le, nop_ex, ifid_flush,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_ra, id_rb, id_rd,
        input  id_use_ra, id_use_rb, id_use_rd,
        input  id_rf_e, id_load, branch_taken,
        output sel_pa, sel_pb, sel_pd,
        output pc_le, ifid_le, nop_ex, ifid_flush,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_stage_tracker.sv
// Three-deep shadow of EX/MEM/WB destination info;
// a stall drops a bubble into EX while older entries advance.
module hazard_stage_tracker
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  stage_ent_t id_ent,
    output stage_ent_t ex_ent,
    output stage_ent_t mem_ent,
    output stage_ent_t wb_ent
);

    stage_ent_t ex_q, ex_d;
    stage_ent_t mem_q, mem_d;
    stage_ent_t wb_q, wb_d;

    always_comb begin
        ex_d  = stall ? '0 : id_ent;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_ent  = ex_q;
    assign mem_ent = mem_q;
    assign wb_ent  = wb_q;

endmodule

// File: rtl/hazard_controller.sv
// Forwarding select, load-use stall and branch flush generation
// from the shadow pipeline, plus saturating bring-up counters.
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  hz
);

    stage_ent_t id_ent;
    stage_ent_t ex_e;
    stage_ent_t mem_e;
    stage_ent_t wb_e;
    logic       stall;
    logic       flush;
    fwd_sel_t   sel_pa;
    fwd_sel_t   sel_pb;
    fwd_sel_t   sel_pd;
    logic       unused_load;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign id_ent = '{
        valid: 1'b1,
        rf_e:  hz.id_rf_e,
        load:  hz.id_load,
        dest:  hz.id_rd
    };

    hazard_stage_tracker u_trk (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .id_ent  (id_ent),
        .ex_ent  (ex_e),
        .mem_ent (mem_e),
        .wb_ent  (wb_e)
    );

    // Older stages only carry the load flag for the trip down the pipe.
    assign unused_load = mem_e.load ^ wb_e.load;

    function automatic fwd_sel_t pick(
        logic       used,
        logic [3:0] src,
        stage_ent_t ex,
        stage_ent_t mem,
        stage_ent_t wb
    );
        if (ent_hit(ex, used, src))
            return FWD_EX;
        else if (ent_hit(mem, used, src))
            return FWD_MEM;
        else if (ent_hit(wb, used, src))
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        stall = ex_e.load & (
            ent_hit(ex_e, hz.id_use_ra, hz.id_ra) |
            ent_hit(ex_e, hz.id_use_rb, hz.id_rb) |
            ent_hit(ex_e, hz.id_use_rd, hz.id_rd));
        flush  = hz.branch_taken & ~stall;
        sel_pa = FWD_RF;
        sel_pb = FWD_RF;
        sel_pd = FWD_RF;
        if (!stall) begin
            sel_pa = pick(hz.id_use_ra, hz.id_ra,
                          ex_e, mem_e, wb_e);
            sel_pb = pick(hz.id_use_rb, hz.id_rb,
                          ex_e, mem_e, wb_e);
            sel_pd = pick(hz.id_use_rd, hz.id_rd,
                          ex_e, mem_e, wb_e);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.sel_pa     = sel_pa;
    assign hz.sel_pb     = sel_pb;
    assign hz.sel_pd     = sel_pd;
    assign hz.pc_le      = ~stall;
    assign hz.ifid_le    = ~stall;
    assign hz.nop_ex     = stall;
    assign hz.ifid_flush = flush;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed hazard scenarios then random
// instruction streams, all checked against an age-list reference model.
module tb_hazard_controller;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    typedef struct {
        logic [3:0] ra, rb, rd;
        logic ua, ub, ud, rfe, ld, br;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    // Model: issued history, newest first (age 0 = EX).
    int hw[3], hd[3], hl[3];
    int m_sc, m_fc;
    bit e_stall, e_flush;
    ins_t cur;

    hazard_controller_if #(.CNT_W(CW)) ifc ();

    hazard_controller #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .hz    (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t mk(int ra, int ua, int rb, int ub,
                                int rd, int ud, int rfe, int ld,
                                int br);
        ins_t i;
        i.ra = 4'(ra); i.rb = 4'(rb); i.rd = 4'(rd);
        i.ua = ua[0]; i.ub = ub[0]; i.ud = ud[0];
        i.rfe = rfe[0]; i.ld = ld[0]; i.br = br[0];
        return i;
    endfunction

    function automatic int rreg();
        int r = int'($urandom_range(0, 4));
        return (r == 4) ? 15 : r + 1;
    endfunction

    function automatic ins_t rnd();
        return mk(rreg(), int'($urandom_range(0, 1)),
                  rreg(), int'($urandom_range(0, 1)),
                  rreg(), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 5) == 0));
    endfunction

    // Forwarding source = age of the newest writer of src, plus one.
    function automatic int exp_sel(bit used, int src);
        if (!used || src == 15) return 0;
        for (int a = 0; a < 3; a++)
            if (hw[a] != 0 && hd[a] == src) return a + 1;
        return 0;
    endfunction

    function automatic bit ld_dep(bit used, int src);
        return used && src != 15 && hw[0] != 0 &&
               hd[0] == src && hl[0] != 0;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            hw[a] = 0; hd[a] = 0; hl[a] = 0;
        end
        m_sc = 0; m_fc = 0;
        e_stall = 0; e_flush = 0;
    endtask

    task automatic present(ins_t i);
        int pa, pb, pd;
        ifc.id_ra = i.ra; ifc.id_rb = i.rb; ifc.id_rd = i.rd;
        ifc.id_use_ra = i.ua; ifc.id_use_rb = i.ub;
        ifc.id_use_rd = i.ud; ifc.id_rf_e = i.rfe;
        ifc.id_load = i.ld; ifc.branch_taken = i.br;
        #1;
        e_stall = ld_dep(i.ua, i.ra) || ld_dep(i.ub, i.rb) ||
                  ld_dep(i.ud, i.rd);
        e_flush = i.br && !e_stall;
        pa = e_stall ? 0 : exp_sel(i.ua, i.ra);
        pb = e_stall ? 0 : exp_sel(i.ub, i.rb);
        pd = e_stall ? 0 : exp_sel(i.ud, i.rd);
        chk("sel_pa", 32'(ifc.sel_pa), 32'(pa));
        chk("sel_pb", 32'(ifc.sel_pb), 32'(pb));
        chk("sel_pd", 32'(ifc.sel_pd), 32'(pd));
        chk("pc_le", 32'(ifc.pc_le), 32'(!e_stall));
        chk("ifid_le", 32'(ifc.ifid_le), 32'(!e_stall));
        chk("nop_ex", 32'(ifc.nop_ex), 32'(e_stall));
        chk("ifid_flush", 32'(ifc.ifid_flush), 32'(e_flush));
        chk("stall_cnt", 32'(ifc.stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(ifc.flush_cnt), 32'(m_fc));
    endtask

    task automatic advance();
        @(posedge clk);
        for (int a = 2; a > 0; a--) begin
            hw[a] = hw[a-1]; hd[a] = hd[a-1]; hl[a] = hl[a-1];
        end
        hw[0] = e_stall ? 0 : int'(cur.rfe);
        hd[0] = int'(cur.rd);
        hl[0] = e_stall ? 0 : int'(cur.ld);
        if (e_stall && m_sc < MAX) m_sc++;
        if (e_flush && m_fc < MAX) m_fc++;
        @(negedge clk);
    endtask

    task automatic step(ins_t i);
        cur = i;
        present(i);
        advance();
    endtask

    initial begin
        ins_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cur = nop;
        model_reset();
        ifc.id_ra = 0; ifc.id_rb = 0; ifc.id_rd = 0;
        ifc.id_use_ra = 0; ifc.id_use_rb = 0; ifc.id_use_rd = 0;
        ifc.id_rf_e = 0; ifc.id_load = 0; ifc.branch_taken = 0;
        @(negedge clk);
        chk("rst_sel_pa", 32'(ifc.sel_pa), 0);
        chk("rst_pc_le", 32'(ifc.pc_le), 1);
        chk("rst_nop_ex", 32'(ifc.nop_ex), 0);
        chk("rst_stall_cnt", 32'(ifc.stall_cnt), 0);
        rst_n = 1'b1;

        // ALU producer r1, then consumers walking down the pipe
        step(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
        cur = mk(1, 1, 3, 1, 2, 0, 1, 0, 0);
        present(cur);
        chk("fwd_ex", 32'(ifc.sel_pa), 1);
        advance();
        cur = mk(1, 1, 0, 0, 7, 0, 0, 0, 0);
        present(cur);
        chk("fwd_mem", 32'(ifc.sel_pa), 2);
        advance();
        present(cur);
        chk("fwd_wb", 32'(ifc.sel_pa), 3);
        advance();
        present(cur);
        chk("fwd_rf", 32'(ifc.sel_pa), 0);
        advance();

        // Load-use: one bubble then MEM forward
        step(mk(0, 0, 0, 0, 5, 0, 1, 1, 0));
        cur = mk(5, 1, 1, 1, 2, 0, 1, 0, 0);
        present(cur);
        chk("lu_nop_ex", 32'(ifc.nop_ex), 1);
        advance();
        present(cur);
        chk("lu_stall_cnt", 32'(ifc.stall_cnt), 1);
        chk("lu_fwd_mem", 32'(ifc.sel_pa), 2);
        advance();

        // Stall masks a taken branch for one cycle
        step(mk(0, 0, 0, 0, 5, 0, 1, 1, 0));
        cur = mk(5, 1, 0, 0, 0, 0, 0, 0, 1);
        present(cur);
        chk("br_masked", 32'(ifc.ifid_flush), 0);
        advance();
        present(cur);
        chk("br_flush", 32'(ifc.ifid_flush), 1);
        advance();
        present(nop);
        chk("br_flush_cnt", 32'(ifc.flush_cnt), 1);
        cur = nop;
        advance();

        // R15 never forwards or stalls
        step(mk(0, 0, 0, 0, 15, 0, 1, 0, 0));
        cur = mk(15, 1, 15, 1, 0, 0, 0, 0, 0);
        present(cur);
        chk("r15_nofwd", 32'(ifc.sel_pa), 0);
        advance();
        step(mk(0, 0, 0, 0, 15, 0, 1, 1, 0));
        cur = mk(15, 1, 0, 0, 0, 0, 0, 0, 0);
        present(cur);
        chk("r15_nostall", 32'(ifc.pc_le), 1);
        advance();

        // Reset asserted in the middle of a stall
        step(mk(0, 0, 0, 0, 5, 0, 1, 1, 0));
        cur = mk(5, 1, 0, 0, 2, 0, 1, 0, 0);
        present(cur);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_nop_ex", 32'(ifc.nop_ex), 0);
        chk("mid_rst_pc_le", 32'(ifc.pc_le), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        present(cur);
        chk("post_rst_nostall", 32'(ifc.nop_ex), 0);
        advance();

        // Random stream; held instruction on stall, NOP after flush
        for (int n = 0; n < 600; n++) begin
            if (e_stall) cur = cur;
            else if (e_flush) cur = nop;
            else cur = rnd();
            present(cur);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
